mem_access_ctrl: RTL and testbench

Sequencing controller for the MEM-stage data RAM (256x32, byte/halfword/word access). It accepts one load/store request at a time from the MEM stage and checks alignment and range. It drives the RAM enable/RW/size/address/data lines for a fixed access latency, sign- or zero-extends load data, and stalls the pipeline until the access completes.

---
 rtl/mem_access_ctrl_if.sv | 30 +++
 rtl/mem_access_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline, the access controller and the data RAM.
// The master side issues requests and supplies RAM read data; the slave side is the controller.
interface mem_access_ctrl_if;
  logic        ReqValid;
  logic        ReqRW;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqData;
  logic        RamEnable;
  logic        RamRW;
  logic [1:0]  RamSize;
  logic [31:0] RamAddr;
  logic [31:0] RamDataOut;
  logic [31:0] RamDataIn;
  logic        Stall;
  logic        Done;
  logic [31:0] RdData;
  logic        AlignFault;

  modport master (
    output ReqValid, ReqRW, ReqSize, ReqSigned, ReqAddr, ReqData, RamDataIn,
    input  RamEnable, RamRW, RamSize, RamAddr, RamDataOut, Stall, Done, RdData, AlignFault
  );

  modport slave (
    input  ReqValid, ReqRW, ReqSize, ReqSigned, ReqAddr, ReqData, RamDataIn,
    output RamEnable, RamRW, RamSize, RamAddr, RamDataOut, Stall, Done, RdData, AlignFault
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequencing controller for the MEM-stage data RAM: validates one load/store at a time,
// holds the RAM lines for a fixed latency, extends load data and stalls the pipeline meanwhile.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_BYTES   = 1024
) (
  input  logic             Clk,
  input  logic             ResetN,
  mem_access_ctrl_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_wait;
  logic               r_ram_en;
  logic               r_ram_rw;
  logic [1:0]         r_ram_size;
  logic [31:0]        r_ram_addr;
  logic [31:0]        r_ram_data;
  logic               r_signed;
  logic [31:0]        r_rd_data;
  logic               r_done;
  logic               r_align_fault;
  logic               w_fault;

  // Misaligned, reserved-size and out-of-range requests are all rejected without touching the RAM.
  function automatic logic f_fault(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    if (size == 2'b11)                          bad = 1'b1;
    if ((size == 2'b10) && (addr[1:0] != 2'b00)) bad = 1'b1;
    if ((size == 2'b01) && addr[0])              bad = 1'b1;
    if (addr >= 32'(MEM_BYTES))                 bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] size,
                                           input logic sgn);
    logic [31:0] res;
    case (size)
      2'b00:   res = {{24{sgn & d[7]}},  d[7:0]};
      2'b01:   res = {{16{sgn & d[15]}}, d[15:0]};
      default: res = d;
    endcase
    return res;
  endfunction

  assign w_fault = f_fault(bus.ReqSize, bus.ReqAddr);

  // Stall is held low while in reset so a pending ReqValid cannot freeze the pipeline.
  assign bus.Stall = ResetN &&
                     (((r_state == S_IDLE) && bus.ReqValid) || (r_state == S_ACCESS));

  assign bus.RamEnable  = r_ram_en;
  assign bus.RamRW      = r_ram_rw;
  assign bus.RamSize    = r_ram_size;
  assign bus.RamAddr    = r_ram_addr;
  assign bus.RamDataOut = r_ram_data;
  assign bus.RdData     = r_rd_data;
  assign bus.Done       = r_done;
  assign bus.AlignFault = r_align_fault;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_ram_en      <= 1'b0;
      r_ram_rw      <= 1'b1;
      r_ram_size    <= 2'b00;
      r_ram_addr    <= '0;
      r_ram_data    <= '0;
      r_signed      <= 1'b0;
      r_rd_data     <= '0;
      r_done        <= 1'b0;
      r_align_fault <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_align_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.ReqValid) begin
            if (w_fault) begin
              r_align_fault <= 1'b1;
              r_state       <= S_FAULT;
            end else begin
              r_ram_rw   <= bus.ReqRW;
              r_ram_size <= bus.ReqSize;
              r_signed   <= bus.ReqSigned;
              r_ram_addr <= bus.ReqAddr;
              r_ram_data <= bus.ReqData;
              r_wait     <= CNT_W'(WAIT_CYCLES);
              r_ram_en   <= 1'b1;
              r_state    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - CNT_W'(1);
          end else begin
            // Only loads update RdData; it then holds until the next load completes.
            if (r_ram_rw) begin
              r_rd_data <= f_extend(bus.RamDataIn, r_ram_size, r_signed);
            end
            r_ram_en <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_CYCLES=1, MEM_BYTES=1024.
module tb_mem_access_ctrl;

  logic Clk;
  logic ResetN;
  int   cyc;
  int   n_cmp;
  int   n_err;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .WAIT_CYCLES (1),
    .MEM_BYTES   (1024)
  ) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Results of the most recent do_req call.
  int          en_cnt, stall_cnt, done_cyc, done_n, fault_cyc, start_cyc;
  logic [31:0] seen_addr, seen_data;
  logic        seen_rw;
  logic [1:0]  seen_size;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  // Issue one request in the current IDLE cycle and follow it until Done/AlignFault,
  // returning in the following IDLE cycle.
  task automatic do_req(input logic rw, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdin, input logic churn);
    bit fin;
    en_cnt = 0; stall_cnt = 0; done_cyc = -1; done_n = 0; fault_cyc = -1;
    seen_addr = 'x; seen_data = 'x; seen_rw = 1'bx; seen_size = 2'bxx;
    bus.ReqValid  = 1'b1;
    bus.ReqRW     = rw;
    bus.ReqSize   = size;
    bus.ReqSigned = sgn;
    bus.ReqAddr   = addr;
    bus.ReqData   = data;
    bus.RamDataIn = rdin;
    #1;
    start_cyc = cyc;
    stall_cnt += int'(bus.Stall);
    fin = 1'b0;
    for (int c = 1; c <= 12 && !fin; c++) begin
      step();
      en_cnt    += int'(bus.RamEnable);
      stall_cnt += int'(bus.Stall);
      if (bus.RamEnable) begin
        seen_addr = bus.RamAddr;
        seen_data = bus.RamDataOut;
        seen_rw   = bus.RamRW;
        seen_size = bus.RamSize;
      end
      if (churn && c == 1) begin
        bus.ReqAddr   = addr ^ 32'h0000_0044;
        bus.ReqData   = ~data;
        bus.ReqSigned = ~sgn;
      end
      if (bus.Done) begin
        done_n++;
        done_cyc = c;
      end
      if (bus.AlignFault) fault_cyc = c;
      if (bus.Done || bus.AlignFault) begin
        bus.ReqValid = 1'b0;
        fin = 1'b1;
      end
    end
    bus.ReqValid = 1'b0;
    step();
  endtask

  int start_a;

  initial begin
    n_cmp = 0;
    n_err = 0;
    ResetN        = 1'b0;
    bus.ReqValid  = 1'b1;
    bus.ReqRW     = 1'b1;
    bus.ReqSize   = 2'b10;
    bus.ReqSigned = 1'b0;
    bus.ReqAddr   = 32'h0000_0010;
    bus.ReqData   = 32'h1111_2222;
    bus.RamDataIn = 32'h0;
    step();
    step();

    // Reset values, with a request pending
    chk("rst_RamEnable",  32'(bus.RamEnable), 32'd0);
    chk("rst_RamRW",      32'(bus.RamRW), 32'd1);
    chk("rst_RamSize",    32'(bus.RamSize), 32'd0);
    chk("rst_RamAddr",    bus.RamAddr, 32'h0);
    chk("rst_RamDataOut", bus.RamDataOut, 32'h0);
    chk("rst_RdData",     bus.RdData, 32'h0);
    chk("rst_Done",       32'(bus.Done), 32'd0);
    chk("rst_AlignFault", 32'(bus.AlignFault), 32'd0);
    chk("rst_Stall",      32'(bus.Stall), 32'd0);
    bus.ReqValid = 1'b0;
    ResetN = 1'b1;
    step();
    chk("idle_Stall", 32'(bus.Stall), 32'd0);

    // Word store then word load
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("st_en_cycles",   32'(en_cnt), 32'd2);
    chk("st_done_cyc",    32'(done_cyc), 32'd3);
    chk("st_done_pulses", 32'(done_n), 32'd1);
    chk("st_stall_cyc",   32'(stall_cnt), 32'd3);
    chk("st_RamAddr",     seen_addr, 32'h10);
    chk("st_RamDataOut",  seen_data, 32'hDEADBEEF);
    chk("st_RamRW",       32'(seen_rw), 32'd0);
    chk("st_RamSize",     32'(seen_size), 32'd2);
    chk("st_RdData_kept", bus.RdData, 32'h0);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("ld_en_cycles", 32'(en_cnt), 32'd2);
    chk("ld_done_cyc",  32'(done_cyc), 32'd3);
    chk("ld_stall_cyc", 32'(stall_cnt), 32'd3);
    chk("ld_RamRW",     32'(seen_rw), 32'd1);
    chk("ld_RdData",    bus.RdData, 32'hDEADBEEF);

    // A later store leaves RdData alone
    do_req(1'b0, 2'b00, 1'b1, 32'h3, 32'h0000_00AA, 32'hFFFF_FFFF, 1'b0);
    chk("st2_done_cyc",  32'(done_cyc), 32'd3);
    chk("st2_RdData",    bus.RdData, 32'hDEADBEEF);

    // Byte and halfword extension
    do_req(1'b1, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000_0080, 1'b0);
    chk("ldb_s_RdData", bus.RdData, 32'hFFFF_FF80);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000_0080, 1'b0);
    chk("ldb_u_RdData", bus.RdData, 32'h0000_0080);
    do_req(1'b1, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
    chk("ldh_s_RdData", bus.RdData, 32'hFFFF_8001);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0, 32'h1234_F00D, 1'b0);
    chk("ldh_u_RdData", bus.RdData, 32'h0000_F00D);
    do_req(1'b1, 2'b00, 1'b1, 32'h3FF, 32'h0, 32'hABCD_EF7F, 1'b0);
    chk("ldb_last_done", 32'(done_cyc), 32'd3);
    chk("ldb_s_pos",     bus.RdData, 32'h0000_007F);

    // Faults: word at 0x12, halfword at 0x13, reserved size, out of range
    do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h0, 32'h5555_5555, 1'b0);
    chk("fw_fault_cyc", 32'(fault_cyc), 32'd1);
    chk("fw_en_cycles", 32'(en_cnt), 32'd0);
    chk("fw_done",      32'(done_n), 32'd0);
    chk("fw_stall_cyc", 32'(stall_cnt), 32'd1);
    do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0, 32'h5555_5555, 1'b0);
    chk("fh_fault_cyc", 32'(fault_cyc), 32'd1);
    chk("fh_en_cycles", 32'(en_cnt), 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h1, 32'h5555_5555, 1'b0);
    chk("fs_fault_cyc", 32'(fault_cyc), 32'd1);
    chk("fs_en_cycles", 32'(en_cnt), 32'd0);
    do_req(1'b1, 2'b00, 1'b0, 32'd1024, 32'h0, 32'h5555_5555, 1'b0);
    chk("fr_fault_cyc", 32'(fault_cyc), 32'd1);
    chk("fr_en_cycles", 32'(en_cnt), 32'd0);
    chk("fr_done",      32'(done_n), 32'd0);
    chk("fault_RdData", bus.RdData, 32'h0000_007F);

    // Reset in the middle of an access
    bus.ReqValid  = 1'b1;
    bus.ReqRW     = 1'b1;
    bus.ReqSize   = 2'b10;
    bus.ReqSigned = 1'b0;
    bus.ReqAddr   = 32'h40;
    bus.RamDataIn = 32'h0BAD_0BAD;
    step();
    chk("mr_en_before", 32'(bus.RamEnable), 32'd1);
    ResetN = 1'b0;
    #1;
    chk("mr_en_async",    32'(bus.RamEnable), 32'd0);
    chk("mr_stall_async", 32'(bus.Stall), 32'd0);
    chk("mr_addr_async",  bus.RamAddr, 32'h0);
    chk("mr_rd_async",    bus.RdData, 32'h0);
    step();
    chk("mr_done_1", 32'(bus.Done), 32'd0);
    step();
    chk("mr_done_2", 32'(bus.Done), 32'd0);
    bus.ReqValid = 1'b0;
    ResetN = 1'b1;
    step();
    chk("mr_done_3", 32'(bus.Done), 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 1'b0);
    chk("mr_fresh_done", 32'(done_cyc), 32'd3);
    chk("mr_fresh_rd",   bus.RdData, 32'h1234_5678);

    // Input churn during ACCESS, then back-to-back spacing
    do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'hCAFE_F00D, 32'h0, 1'b1);
    chk("ch_RamAddr",    seen_addr, 32'h80);
    chk("ch_RamDataOut", seen_data, 32'hCAFE_F00D);
    do_req(1'b1, 2'b00, 1'b1, 32'h81, 32'h0, 32'h0000_00F0, 1'b1);
    start_a = start_cyc;
    chk("ch_ld_RdData", bus.RdData, 32'hFFFF_FFF0);
    do_req(1'b1, 2'b01, 1'b0, 32'h84, 32'h0, 32'h0000_9ABC, 1'b0);
    chk("b2b_spacing",  32'(start_cyc - start_a), 32'd4);
    chk("b2b_RdData",   bus.RdData, 32'h0000_9ABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
